// File: rtl/ysyx_bus_pkg.sv
`default_nettype none
// =============================================================================
// ysyx_bus_pkg : AXI4-Lite response/size codes and LSU bridge state encoding
// Revision     : 1.0
// =============================================================================
package ysyx_bus_pkg;

    localparam logic [1:0] c_RESP_OKAY   = 2'd0;
    localparam logic [1:0] c_RESP_SLVERR = 2'd2;
    localparam logic [1:0] c_RESP_DECERR = 2'd3;

    localparam logic [2:0] c_SIZE_1B = 3'd0;
    localparam logic [2:0] c_SIZE_2B = 3'd1;
    localparam logic [2:0] c_SIZE_4B = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_COOL    = 3'd5
    } bridge_state_e;

    // Right-aligned LSU byte mask to AXI xSIZE; anything wider than a half
    // word is issued as a full word.
    function automatic logic [2:0] size_from_strb(input logic [7:0] strb);
        case (strb)
            8'h01:   return c_SIZE_1B;
            8'h03:   return c_SIZE_2B;
            default: return c_SIZE_4B;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// =============================================================================
// lsu_lane_align : byte-lane shifter between right-aligned LSU data and the bus
// Revision       : 1.0
// =============================================================================
module lsu_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]          addr_lo_i,
    input  logic [DATA_W-1:0]   st_data_i,
    input  logic [DATA_W/8-1:0] st_strb_i,
    input  logic [DATA_W-1:0]   ld_bus_data_i,
    output logic [DATA_W-1:0]   st_bus_data_o,
    output logic [DATA_W/8-1:0] st_bus_strb_o,
    output logic [DATA_W-1:0]   ld_data_o
);

    logic [4:0] w_bit_shift;

    assign w_bit_shift = {addr_lo_i, 3'b000};

    // Lanes pushed past the top of the word are simply lost: word-crossing
    // accesses are not split.
    assign st_bus_data_o = st_data_i << w_bit_shift;
    assign st_bus_strb_o = st_strb_i << addr_lo_i;
    assign ld_data_o     = ld_bus_data_i >> w_bit_shift;

endmodule
`default_nettype wire

// File: rtl/lsu_axi_bridge.sv
`default_nettype none
// =============================================================================
// lsu_axi_bridge : LSU level-valid load/store -> AXI4-Lite master, one in flight
// Revision       : 1.0
// =============================================================================
module lsu_axi_bridge
    import ysyx_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    // LSU load side
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    input  logic [7:0]          lsu_rstrb,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_rvalid,
    // LSU store side
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [7:0]          lsu_wstrb,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic                lsu_fault,
    // AXI4-Lite AR/R
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    output logic [2:0]          m_arsize,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready,
    // AXI4-Lite AW/W/B
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    output logic [2:0]          m_awsize,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready
);

    bridge_state_e       state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          strb_q, strb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic                wready_q, wready_d;
    logic                fault_q, fault_d;

    logic [DATA_W-1:0]   w_st_bus_data;
    logic [DATA_W/8-1:0] w_st_bus_strb;
    logic [DATA_W-1:0]   w_ld_data;

    lsu_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .addr_lo_i     (addr_q[1:0]),
        .st_data_i     (data_q),
        .st_strb_i     (strb_q[DATA_W/8-1:0]),
        .ld_bus_data_i (m_rdata),
        .st_bus_data_o (w_st_bus_data),
        .st_bus_strb_o (w_st_bus_strb),
        .ld_data_o     (w_ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            wready_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            wready_q  <= wready_d;
            fault_q   <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        wready_d  = 1'b0;
        fault_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Loads take priority over a simultaneous store request.
                if (lsu_arvalid) begin
                    addr_d  = lsu_araddr;
                    strb_d  = lsu_rstrb;
                    state_d = ST_RD_ADDR;
                end else if (lsu_awvalid && lsu_wvalid) begin
                    addr_d    = lsu_awaddr;
                    data_d    = lsu_wdata;
                    strb_d    = lsu_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_REQ;
                end
            end
            ST_RD_ADDR: begin
                if (m_arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (m_rvalid) begin
                    rdata_d  = w_ld_data;
                    rvalid_d = 1'b1;
                    fault_d  = (m_rresp != c_RESP_OKAY);
                    state_d  = ST_COOL;
                end
            end
            ST_WR_REQ: begin
                // AW and W complete independently and may finish in either order.
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q  | (m_wvalid  & m_wready);
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (m_bvalid) begin
                    wready_d = 1'b1;
                    fault_d  = (m_bresp != c_RESP_OKAY);
                    state_d  = ST_COOL;
                end
            end
            ST_COOL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every bus-side valid/ready comes from registered state only.
    assign m_araddr  = addr_q;
    assign m_arvalid = (state_q == ST_RD_ADDR);
    assign m_arsize  = size_from_strb(strb_q);
    assign m_rready  = (state_q == ST_RD_DATA);

    assign m_awaddr  = addr_q;
    assign m_awvalid = (state_q == ST_WR_REQ) && !aw_done_q;
    assign m_awsize  = size_from_strb(strb_q);
    assign m_wdata   = w_st_bus_data;
    assign m_wstrb   = w_st_bus_strb;
    assign m_wvalid  = (state_q == ST_WR_REQ) && !w_done_q;
    assign m_bready  = (state_q == ST_WR_RESP);

    assign lsu_rdata  = rdata_q;
    assign lsu_rvalid = rvalid_q;
    assign lsu_wready = wready_q;
    assign lsu_fault  = fault_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_bridge.sv
`default_nettype none
// =============================================================================
// tb_lsu_axi_bridge : randomized bench for lsu_axi_bridge with behavioural model
// Revision          : 1.0
// =============================================================================
module tb_lsu_axi_bridge;

    logic        clk;
    logic        rst_n;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic [7:0]  lsu_rstrb;
    logic [31:0] lsu_rdata;
    logic        lsu_rvalid;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid;
    logic [31:0] lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_wvalid;
    logic        lsu_wready;
    logic        lsu_fault;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic [2:0]  m_arsize;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic [2:0]  m_awsize;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;

    int n_total = 0;
    int n_bad   = 0;

    lsu_axi_bridge #(.ADDR_W(32), .DATA_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
        .lsu_rdata(lsu_rdata), .lsu_rvalid(lsu_rvalid),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_fault(lsu_fault),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arsize(m_arsize), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awsize(m_awsize), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: byte lanes by plain arithmetic.
    function automatic logic [31:0] mdl_ld(input logic [31:0] bus, input logic [1:0] off);
        logic [31:0] div;
        div = 32'd1 << (8 * int'(off));
        return bus / div;
    endfunction

    function automatic logic [31:0] mdl_st_data(input logic [31:0] wd, input logic [1:0] off);
        logic [63:0] p;
        p = 64'(wd) * (64'd1 << (8 * int'(off)));
        return p[31:0];
    endfunction

    function automatic logic [3:0] mdl_st_strb(input logic [7:0] s, input logic [1:0] off);
        logic [3:0] r;
        r = '0;
        for (int lane = 0; lane < 4; lane++)
            if (lane >= int'(off) && s[lane - int'(off)]) r[lane] = 1'b1;
        return r;
    endfunction

    function automatic logic [2:0] mdl_size(input logic [7:0] s);
        int n;
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(s[i]);
        return (n == 1) ? 3'd0 : (n == 2) ? 3'd1 : 3'd2;
    endfunction

    task automatic check_quiet(input string pfx);
        check_val({pfx, "_lsu_rvalid"}, 32'(lsu_rvalid), 32'd0);
        check_val({pfx, "_lsu_wready"}, 32'(lsu_wready), 32'd0);
        check_val({pfx, "_lsu_fault"},  32'(lsu_fault),  32'd0);
        check_val({pfx, "_lsu_rdata"},  lsu_rdata,       32'd0);
        check_val({pfx, "_m_arvalid"},  32'(m_arvalid),  32'd0);
        check_val({pfx, "_m_rready"},   32'(m_rready),   32'd0);
        check_val({pfx, "_m_awvalid"},  32'(m_awvalid),  32'd0);
        check_val({pfx, "_m_wvalid"},   32'(m_wvalid),   32'd0);
        check_val({pfx, "_m_bready"},   32'(m_bready),   32'd0);
        check_val({pfx, "_m_araddr"},   m_araddr,        32'd0);
        check_val({pfx, "_m_wdata"},    m_wdata,         32'd0);
    endtask

    // Plays the LSU and an AXI slave with programmable wait states.
    // Must be entered on a falling edge; returns on a falling edge with the bridge idle.
    task automatic run_txn(
        input bit do_rd, input logic [31:0] raddr, input logic [7:0] rstrb,
        input logic [31:0] sdata, input logic [1:0] rresp, input int arw, input int rw,
        input bit do_wr, input logic [31:0] waddr, input logic [31:0] wdata,
        input logic [7:0] wstrb, input logic [1:0] bresp, input int aww, input int ww, input int bw);
        int cyc, tail, proto, rd_lat, wr_lat;
        int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
        int ar_hs, aw_hs, w_hs, rv_n, wr_n;
        bit ar_seen, aw_seen, w_seen;
        cyc = 0; tail = 0; proto = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        ar_hs = 0; aw_hs = 0; w_hs = 0; rv_n = 0; wr_n = 0;
        ar_seen = 0; aw_seen = 0; w_seen = 0;
        rd_lat = 3 + arw + rw;
        wr_lat = (do_rd ? rd_lat + 1 : 0) + 3 + ((aww > ww) ? aww : ww) + bw;

        lsu_arvalid = do_rd; lsu_araddr = raddr; lsu_rstrb = rstrb;
        lsu_awvalid = do_wr; lsu_wvalid = do_wr;
        lsu_awaddr = waddr; lsu_wdata = wdata; lsu_wstrb = wstrb;

        while (tail < 3 && cyc < 200) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (lsu_fault && !lsu_rvalid && !lsu_wready) proto++;
            if (lsu_rvalid) begin
                rv_n++;
                if (rv_n == 1) begin
                    check_val("ld_rdata", lsu_rdata, mdl_ld(sdata, raddr[1:0]));
                    check_val("ld_fault", 32'(lsu_fault), 32'(rresp != 2'd0));
                    check_val("ld_latency", cyc, rd_lat);
                end
                lsu_arvalid = 1'b0;
                lsu_araddr  = $urandom;
            end
            if (lsu_wready) begin
                wr_n++;
                if (wr_n == 1) begin
                    check_val("st_fault", 32'(lsu_fault), 32'(bresp != 2'd0));
                    check_val("st_latency", cyc, wr_lat);
                end
                lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
                lsu_awaddr  = $urandom; lsu_wdata = $urandom;
            end
            if (do_rd && rv_n == 0 && (m_awvalid || m_wvalid || m_bready)) proto++;

            m_arready = 1'b0;
            if (m_arvalid) begin
                ar_seen = 1;
                if (ar_cnt == arw) begin
                    m_arready = 1'b1;
                    ar_hs++;
                    check_val("araddr", m_araddr, raddr);
                    check_val("arsize", 32'(m_arsize), 32'(mdl_size(rstrb)));
                end
                ar_cnt++;
            end else if (ar_seen && ar_hs == 0) proto++;

            m_rvalid = 1'b0; m_rdata = $urandom; m_rresp = 2'($urandom);
            if (m_rready) begin
                if (r_cnt == rw) begin
                    m_rvalid = 1'b1; m_rdata = sdata; m_rresp = rresp;
                end
                r_cnt++;
            end

            m_awready = 1'b0;
            if (m_awvalid) begin
                aw_seen = 1;
                if (aw_cnt == aww) begin
                    m_awready = 1'b1;
                    aw_hs++;
                    check_val("awaddr", m_awaddr, waddr);
                    check_val("awsize", 32'(m_awsize), 32'(mdl_size(wstrb)));
                end
                aw_cnt++;
            end else if (aw_seen && aw_hs == 0) proto++;

            m_wready = 1'b0;
            if (m_wvalid) begin
                w_seen = 1;
                if (w_cnt == ww) begin
                    m_wready = 1'b1;
                    w_hs++;
                    check_val("wdata", m_wdata, mdl_st_data(wdata, waddr[1:0]));
                    check_val("wstrb", 32'(m_wstrb), 32'(mdl_st_strb(wstrb, waddr[1:0])));
                end
                w_cnt++;
            end else if (w_seen && w_hs == 0) proto++;

            m_bvalid = 1'b0; m_bresp = 2'($urandom);
            if (m_bready) begin
                if (aw_hs == 0 || w_hs == 0) proto++;
                if (b_cnt == bw) begin
                    m_bvalid = 1'b1; m_bresp = bresp;
                end
                b_cnt++;
            end

            if ((!do_rd || rv_n > 0) && (!do_wr || wr_n > 0)) tail++;
        end
        m_arready = 1'b0; m_rvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
        lsu_arvalid = 1'b0; lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        check_val("txn_done", 32'(tail), 32'd3);
        check_val("rvalid_pulses", rv_n, 32'(do_rd));
        check_val("wready_pulses", wr_n, 32'(do_wr));
        check_val("ar_handshakes", ar_hs, 32'(do_rd));
        check_val("aw_handshakes", aw_hs, 32'(do_wr));
        check_val("w_handshakes", w_hs, 32'(do_wr));
        check_val("protocol_errs", proto, 32'd0);
    endtask

    task automatic reset_mid_read();
        int stray;
        stray = 0;
        lsu_arvalid = 1'b1; lsu_araddr = 32'h8000_0010; lsu_rstrb = 8'h0f;
        @(posedge clk); @(negedge clk);
        m_arready = m_arvalid;
        @(posedge clk); @(negedge clk);
        m_arready = 1'b0;
        check_val("rst_mid_rready", 32'(m_rready), 32'd1);
        m_rvalid = 1'b1; m_rdata = 32'h1234_5678; m_rresp = 2'd0;
        #2 rst_n = 1'b0;
        #1 check_quiet("rst_mid");
        m_rvalid = 1'b0; lsu_arvalid = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (lsu_rvalid || m_arvalid || m_rready) stray++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            if (lsu_rvalid || m_arvalid || m_rready || m_awvalid) stray++;
        end
        check_val("rst_mid_stray", stray, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] strb_tab [3];
        logic [1:0] resp_tab [4];
        strb_tab = '{8'h01, 8'h03, 8'h0f};
        resp_tab = '{2'd0, 2'd0, 2'd2, 2'd3};

        rst_n = 1'b1;
        lsu_araddr = '0; lsu_arvalid = 0; lsu_rstrb = '0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0; lsu_wvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = '0; m_rvalid = 0;
        m_awready = 0; m_wready = 0; m_bresp = '0; m_bvalid = 0;
        #1 rst_n = 1'b0;
        #1 check_quiet("rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check_quiet("post_rst");

        // LW, zero wait
        run_txn(1, 32'h8000_0004, 8'h0f, 32'hDEAD_BEEF, 2'd0, 0, 0,
                0, 32'h0, 32'h0, 8'h0, 2'd0, 0, 0, 0);
        // LBU at byte 3
        run_txn(1, 32'h8000_0003, 8'h01, 32'hAB11_2233, 2'd0, 0, 1,
                0, 32'h0, 32'h0, 8'h0, 2'd0, 0, 0, 0);
        // SH at half 1, AW accepted two cycles ahead of W
        run_txn(0, 32'h0, 8'h0, 32'h0, 2'd0, 0, 0,
                1, 32'h8000_0002, 32'h0000_BEEF, 8'h03, 2'd0, 0, 2, 1);
        // SW with SLVERR
        run_txn(0, 32'h0, 8'h0, 32'h0, 2'd0, 0, 0,
                1, 32'h8000_0100, 32'hCAFE_F00D, 8'h0f, 2'd2, 1, 0, 0);
        // Load with DECERR
        run_txn(1, 32'h8000_0200, 8'h0f, 32'h0BAD_0BAD, 2'd3, 1, 2,
                0, 32'h0, 32'h0, 8'h0, 2'd0, 0, 0, 0);
        // Word-crossing store: upper lanes dropped
        run_txn(0, 32'h0, 8'h0, 32'h0, 2'd0, 0, 0,
                1, 32'h8000_0007, 32'h1122_3344, 8'h0f, 2'd0, 0, 0, 0);
        // Simultaneous load and store: load first, store after cooldown
        run_txn(1, 32'h8000_0300, 8'h03, 32'h5566_7788, 2'd0, 0, 0,
                1, 32'h8000_0301, 32'h0000_00A5, 8'h01, 2'd0, 0, 0, 0);

        reset_mid_read();
        run_txn(1, 32'h8000_0020, 8'h0f, 32'h0F0F_A5A5, 2'd0, 0, 0,
                0, 32'h0, 32'h0, 8'h0, 2'd0, 0, 0, 0);

        for (int k = 0; k < 40; k++) begin
            int kind;
            kind = int'($urandom_range(2, 0));
            run_txn(kind != 1, 32'($urandom), strb_tab[$urandom_range(2, 0)], 32'($urandom),
                    resp_tab[$urandom_range(3, 0)], int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                    kind != 0, 32'($urandom), 32'($urandom), strb_tab[$urandom_range(2, 0)],
                    resp_tab[$urandom_range(3, 0)], int'($urandom_range(3, 0)),
                    int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
